// File: rtl/tl_traffic_model_if.sv
// Controller <-> intersection link: lights from the controller, sensors back.
// master = controller side, slave = intersection model side.
interface tl_traffic_model_if;
    logic [1:0] La;
    logic [1:0] Lb;
    logic       Ta;
    logic       Tb;

    modport master (output La, output Lb, input Ta, input Tb);
    modport slave  (input La, input Lb, output Ta, output Tb);
endinterface

// File: rtl/tl_traffic_model.sv
// Intersection model for the traffic-light controller.
// Two identical street channels (index 0 = A, 1 = B), each with a vehicle queue counter fed by
// arrival pulses and drained one car per PASS_CYC green cycles. Ta/Tb report non-empty queues.
// Optional feature macro: TL_MODEL_STAT_EN adds 16-bit served_a/served_b departure counters.
module tl_traffic_model #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned PASS_CYC = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                arrive_a,
    input  logic                arrive_b,
    tl_traffic_model_if.slave   link,
    output logic [CNT_W-1:0]    cnt_a,
    output logic [CNT_W-1:0]    cnt_b,
    output logic                drop_a,
    output logic                drop_b,
    output logic                conflict
`ifdef TL_MODEL_STAT_EN
    ,
    output logic [15:0]         served_a,
    output logic [15:0]         served_b
`endif
);

    localparam int unsigned       TmrW     = $clog2(PASS_CYC) + 1;
    localparam logic [CNT_W-1:0]  CntMax   = '1;
    localparam logic [TmrW-1:0]   TmrLast  = TmrW'(PASS_CYC - 1);
    localparam logic [1:0]        LGreen   = 2'b00;
    localparam logic [1:0]        LIllegal = 2'b11;

    logic [1:0][1:0]        light;
    logic [1:0]             arrive;

    logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0][TmrW-1:0]   tmr_q, tmr_d;
    logic [1:0]             t_q, t_d;
    logic [1:0]             drop_q, drop_d;
    logic [1:0]             depart;
    logic                   conflict_q, conflict_d;

    assign light  = {link.Lb, link.La};
    assign arrive = {arrive_b, arrive_a};

    // Per-street pass timer, departure decision and queue next state.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            tmr_d[s]  = '0;
            depart[s] = 1'b0;
            cnt_d[s]  = cnt_q[s];
            drop_d[s] = 1'b0;
            // Only a green light moves cars; yellow, red and the illegal code all stop
            // the head car and discard its partial progress.
            if (light[s] == LGreen && cnt_q[s] != '0) begin
                if (tmr_q[s] == TmrLast) begin
                    depart[s] = 1'b1;
                end else begin
                    tmr_d[s] = tmr_q[s] + TmrW'(1);
                end
            end
            if (arrive[s] && !depart[s]) begin
                if (cnt_q[s] == CntMax) begin
                    drop_d[s] = 1'b1;
                end else begin
                    cnt_d[s] = cnt_q[s] + CNT_W'(1);
                end
            end else if (depart[s] && !arrive[s]) begin
                cnt_d[s] = cnt_q[s] - CNT_W'(1);
            end
            t_d[s] = (cnt_d[s] != '0);
        end
    end

    // Sticky conflict flag: both green at once, or an illegal light code on either street.
    always_comb begin
        conflict_d = conflict_q;
        if ((light[0] == LGreen && light[1] == LGreen) ||
            light[0] == LIllegal || light[1] == LIllegal) begin
            conflict_d = 1'b1;
        end
    end

    // Queue, timer, sensor and pulse state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            tmr_q      <= '0;
            t_q        <= '0;
            drop_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            t_q        <= t_d;
            drop_q     <= drop_d;
            conflict_q <= conflict_d;
        end
    end

    assign cnt_a    = cnt_q[0];
    assign cnt_b    = cnt_q[1];
    assign link.Ta  = t_q[0];
    assign link.Tb  = t_q[1];
    assign drop_a   = drop_q[0];
    assign drop_b   = drop_q[1];
    assign conflict = conflict_q;

`ifdef TL_MODEL_STAT_EN
    logic [1:0][15:0] served_q, served_d;

    // Total departures per street; wraps naturally at 16 bits.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            served_d[s] = served_q[s] + {15'd0, depart[s]};
        end
    end

    // Departure statistics registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            served_q <= '0;
        end else begin
            served_q <= served_d;
        end
    end

    assign served_a = served_q[0];
    assign served_b = served_q[1];
`endif

endmodule
